// File: rtl/core_reg_bank_if.sv
// Register-list sequencer beat channel between core_reg_bank (master) and the load-store unit (slave).
interface core_reg_bank_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 4
);
    logic              seq_valid;
    logic              seq_ready;
    logic [AW-1:0]     seq_addr;
    logic [DATA_W-1:0] seq_rdata;
    logic [DATA_W-1:0] seq_wdata;
    logic [AW:0]       seq_idx;
    logic [AW:0]       seq_count;

    modport master (
        output seq_valid, seq_addr, seq_rdata, seq_idx, seq_count,
        input  seq_ready, seq_wdata
    );

    modport slave (
        input  seq_valid, seq_addr, seq_rdata, seq_idx, seq_count,
        output seq_ready, seq_wdata
    );
endinterface

// File: rtl/core_reg_bank.sv
// Cortex-M0 core register bank with banked MSP/PSP and a PUSH/POP/LDM/STM list sequencer.
// Define CORE_REG_WR_BYPASS_EN to forward same-cycle write data onto the read ports.
module core_reg_bank #(
    parameter int                DATA_W   = 32,
    parameter int                NREG     = 16,
    parameter int                AW       = 4,
    parameter logic [DATA_W-1:0] RESET_SP = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     addr_Rn,
    input  logic [AW-1:0]     addr_Rm,
    input  logic [AW-1:0]     addr_Rd,
    output logic [DATA_W-1:0] Rn,
    output logic [DATA_W-1:0] Rm,
    output logic [DATA_W-1:0] r_Rd,
    input  logic              ld_rd,
    input  logic [DATA_W-1:0] w_Rd,
    input  logic              ld_sp,
    input  logic              ld_lr,
    input  logic              ld_pc,
    input  logic [DATA_W-1:0] w_SP,
    input  logic [DATA_W-1:0] w_LR,
    input  logic [DATA_W-1:0] w_PC,
    output logic [DATA_W-1:0] r_SP,
    output logic [DATA_W-1:0] r_LR,
    output logic [DATA_W-1:0] r_PC,
    input  logic              ld_apsr,
    input  logic [3:0]        w_APSR,
    output logic [3:0]        r_APSR,
    input  logic              ld_ipsr,
    input  logic [5:0]        w_IPSR,
    output logic [5:0]        r_IPSR,
    input  logic              ld_primask,
    input  logic              w_PMask,
    output logic              r_PMask,
    input  logic              ld_spsel,
    input  logic              w_spsel,
    output logic              r_spsel,
    input  logic              seq_start,
    input  logic              seq_load,
    input  logic [NREG-1:0]   seq_list,
    output logic              seq_busy,
    output logic              seq_done,
    core_reg_bank_if.master   mem
);

    localparam int SP_IDX = 13;
    localparam int LR_IDX = 14;
    localparam int PC_IDX = 15;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DONE} seq_state_t;

    seq_state_t        state;
    logic [NREG-1:0]   remain;
    logic              load_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic [AW:0]       idx_q;
    logic [AW:0]       count_q;

    // regs[SP_IDX] holds MSP; PSP lives separately and is swapped in by view.
    logic [DATA_W-1:0] regs    [NREG];
    logic [DATA_W-1:0] view    [NREG];
    logic [DATA_W-1:0] nx_view [NREG];
    logic [DATA_W-1:0] psp;
    logic [3:0]        apsr;
    logic [5:0]        ipsr;
    logic              primask;
    logic              spsel;

    logic              use_psp;
    logic [AW-1:0]     cur_addr;
    logic [NREG-1:0]   low_bit;
    logic              last_beat;
    logic              seq_we;

    function automatic logic [AW:0] popcnt(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + (AW+1)'(v[i]);
        end
        return c;
    endfunction

    assign use_psp   = spsel && (ipsr == 6'd0);
    assign low_bit   = remain & (~remain + NREG'(1));
    assign last_beat = ((remain & (remain - NREG'(1))) == '0);
    assign seq_we    = (state == SEQ_RUN) && mem.seq_ready && load_q;

    always_comb begin
        cur_addr = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (remain[i]) cur_addr = AW'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) view[i] = regs[i];
        view[SP_IDX] = use_psp ? psp : regs[SP_IDX];
    end

    // Later assignments win, so the order encodes ld_rd < dedicated loads < sequencer.
    always_comb begin
        for (int i = 0; i < NREG; i++) nx_view[i] = view[i];
        if (ld_rd) nx_view[addr_Rd] = w_Rd;
        if (ld_sp) nx_view[SP_IDX] = w_SP;
        if (ld_lr) nx_view[LR_IDX] = w_LR;
        if (ld_pc) nx_view[PC_IDX] = w_PC;
        if (seq_we) nx_view[cur_addr] = mem.seq_wdata;
    end

    always_comb begin
`ifdef CORE_REG_WR_BYPASS_EN
        Rn            = nx_view[addr_Rn];
        Rm            = nx_view[addr_Rm];
        r_Rd          = nx_view[addr_Rd];
        mem.seq_rdata = nx_view[cur_addr];
`else
        Rn            = view[addr_Rn];
        Rm            = view[addr_Rm];
        r_Rd          = view[addr_Rd];
        mem.seq_rdata = view[cur_addr];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == LR_IDX) ? '1 : ((i == SP_IDX) ? RESET_SP : '0);
            end
            psp     <= '0;
            apsr    <= '0;
            ipsr    <= '0;
            primask <= 1'b0;
            spsel   <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (i != SP_IDX) regs[i] <= nx_view[i];
            end
            if (use_psp) psp <= nx_view[SP_IDX];
            else         regs[SP_IDX] <= nx_view[SP_IDX];
            if (ld_apsr)    apsr    <= w_APSR;
            if (ld_ipsr)    ipsr    <= w_IPSR;
            if (ld_primask) primask <= w_PMask;
            if (ld_spsel)   spsel   <= w_spsel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SEQ_IDLE;
            remain  <= '0;
            load_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (seq_start) begin
                        count_q <= popcnt(seq_list);
                        idx_q   <= '0;
                        load_q  <= seq_load;
                        remain  <= seq_list;
                        if (seq_list != '0) begin
                            state   <= SEQ_RUN;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            state  <= SEQ_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                SEQ_RUN: begin
                    if (mem.seq_ready) begin
                        remain <= remain & ~low_bit;
                        idx_q  <= idx_q + (AW+1)'(1);
                        if (last_beat) begin
                            state   <= SEQ_DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SEQ_DONE: begin
                    state  <= SEQ_IDLE;
                    done_q <= 1'b0;
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

    assign r_SP          = view[SP_IDX];
    assign r_LR          = view[LR_IDX];
    assign r_PC          = view[PC_IDX];
    assign r_APSR        = apsr;
    assign r_IPSR        = ipsr;
    assign r_PMask       = primask;
    assign r_spsel       = spsel;
    assign seq_busy      = busy_q;
    assign seq_done      = done_q;
    assign mem.seq_valid = valid_q;
    assign mem.seq_addr  = cur_addr;
    assign mem.seq_idx   = idx_q;
    assign mem.seq_count = count_q;

endmodule

// File: tb/tb_core_reg_bank.sv
// Randomized scoreboard bench for core_reg_bank against an array-based register model.
module tb_core_reg_bank;

    localparam logic [31:0] RST_SP = 32'h2000_4000;
`ifdef CORE_REG_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr_Rn, addr_Rm, addr_Rd;
    logic [31:0] Rn, Rm, r_Rd;
    logic        ld_rd, ld_sp, ld_lr, ld_pc;
    logic [31:0] w_Rd, w_SP, w_LR, w_PC;
    logic [31:0] r_SP, r_LR, r_PC;
    logic        ld_apsr, ld_ipsr, ld_primask, ld_spsel;
    logic [3:0]  w_APSR, r_APSR;
    logic [5:0]  w_IPSR, r_IPSR;
    logic        w_PMask, r_PMask, w_spsel, r_spsel;
    logic        seq_start, seq_load, seq_busy, seq_done;
    logic [15:0] seq_list;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          addr;
        int          idx;
        int          count;
        bit          load;
        logic [31:0] data;
    } beat_t;
    beat_t exp_q[$];

    // Reference state: m_r[13] is unused, the stack pointers are held by name.
    logic [31:0] m_r [16];
    logic [31:0] m_msp, m_psp;
    logic [3:0]  m_apsr;
    logic [5:0]  m_ipsr;
    logic        m_pmask, m_spsel;

    core_reg_bank_if #(.DATA_W(32), .AW(4)) mem ();

    core_reg_bank #(.DATA_W(32), .NREG(16), .AW(4), .RESET_SP(RST_SP)) dut (
        .clk(clk), .rst(rst),
        .addr_Rn(addr_Rn), .addr_Rm(addr_Rm), .addr_Rd(addr_Rd),
        .Rn(Rn), .Rm(Rm), .r_Rd(r_Rd),
        .ld_rd(ld_rd), .w_Rd(w_Rd),
        .ld_sp(ld_sp), .ld_lr(ld_lr), .ld_pc(ld_pc),
        .w_SP(w_SP), .w_LR(w_LR), .w_PC(w_PC),
        .r_SP(r_SP), .r_LR(r_LR), .r_PC(r_PC),
        .ld_apsr(ld_apsr), .w_APSR(w_APSR), .r_APSR(r_APSR),
        .ld_ipsr(ld_ipsr), .w_IPSR(w_IPSR), .r_IPSR(r_IPSR),
        .ld_primask(ld_primask), .w_PMask(w_PMask), .r_PMask(r_PMask),
        .ld_spsel(ld_spsel), .w_spsel(w_spsel), .r_spsel(r_spsel),
        .seq_start(seq_start), .seq_load(seq_load), .seq_list(seq_list),
        .seq_busy(seq_busy), .seq_done(seq_done),
        .mem(mem)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input int a);
        if (a == 13) return (m_spsel && m_ipsr == 6'd0) ? m_psp : m_msp;
        return m_r[a];
    endfunction

    task automatic m_write(input int a, input logic [31:0] v);
        if (a == 13) begin
            if (m_spsel && m_ipsr == 6'd0) m_psp = v;
            else                           m_msp = v;
        end else begin
            m_r[a] = v;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Beat monitor: every presented beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && mem.seq_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat: got addr %0d expected no beat", mem.seq_addr);
            end else begin
                checkOutput("beat_addr", 32'(mem.seq_addr), exp_q[0].addr);
                checkOutput("beat_idx", 32'(mem.seq_idx), exp_q[0].idx);
                checkOutput("beat_count", 32'(mem.seq_count), exp_q[0].count);
                checkOutput("beat_busy", 32'(seq_busy), 32'd1);
                if (!exp_q[0].load) checkOutput("beat_store_data", mem.seq_rdata, exp_q[0].data);
                if (mem.seq_ready) begin
                    if (exp_q[0].load) m_write(exp_q[0].addr, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic clearControls();
        ld_rd = 0; ld_sp = 0; ld_lr = 0; ld_pc = 0;
        ld_apsr = 0; ld_ipsr = 0; ld_primask = 0; ld_spsel = 0;
    endtask

    // Drives one cycle of register-port controls, checks same-cycle reads, then advances.
    task automatic applyStimulus();
        logic [31:0] old_n, old_m, old_d, new_n, new_m, new_d;
        old_n = m_read(int'(addr_Rn));
        old_m = m_read(int'(addr_Rm));
        old_d = m_read(int'(addr_Rd));
        if (ld_rd) m_write(int'(addr_Rd), w_Rd);
        if (ld_sp) m_write(13, w_SP);
        if (ld_lr) m_r[14] = w_LR;
        if (ld_pc) m_r[15] = w_PC;
        new_n = m_read(int'(addr_Rn));
        new_m = m_read(int'(addr_Rm));
        new_d = m_read(int'(addr_Rd));
        #2;
        checkOutput("read_Rn", Rn, BYP ? new_n : old_n);
        checkOutput("read_Rm", Rm, BYP ? new_m : old_m);
        checkOutput("read_Rd", r_Rd, BYP ? new_d : old_d);
        if (ld_apsr)    m_apsr  = w_APSR;
        if (ld_ipsr)    m_ipsr  = w_IPSR;
        if (ld_primask) m_pmask = w_PMask;
        if (ld_spsel)   m_spsel = w_spsel;
        @(posedge clk);
        #1;
        clearControls();
    endtask

    task automatic checkStatus();
        checkOutput("r_SP", r_SP, m_read(13));
        checkOutput("r_LR", r_LR, m_r[14]);
        checkOutput("r_PC", r_PC, m_r[15]);
        checkOutput("r_APSR", 32'(r_APSR), 32'(m_apsr));
        checkOutput("r_IPSR", 32'(r_IPSR), 32'(m_ipsr));
        checkOutput("r_PMask", 32'(r_PMask), 32'(m_pmask));
        checkOutput("r_spsel", 32'(r_spsel), 32'(m_spsel));
    endtask

    task automatic checkAllRegs();
        for (int i = 0; i < 16; i++) begin
            addr_Rn = 4'(i);
            #2;
            checkOutput("reg_read", Rn, m_read(i));
            @(posedge clk);
            #1;
        end
    endtask

    // mode 0: ready held high, 1: ready toggles from 1, 2: random ready plus ignored restarts
    task automatic runWalk(input bit load, input logic [15:0] list, input int mode);
        beat_t e;
        int    n, k, cyc;
        bit    seen;
        n = $countones(list);
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                e.addr  = i;
                e.idx   = k;
                e.count = n;
                e.load  = load;
                e.data  = load ? ((mode == 1) ? 32'hA + 32'(k) : $urandom) : m_read(i);
                exp_q.push_back(e);
                k++;
            end
        end
        seq_start = 1'b1;
        seq_load  = load;
        seq_list  = list;
        @(posedge clk);
        #1;
        seq_start = 1'b0;
        seen = 1'b0;
        cyc  = 1;
        forever begin
            case (mode)
                0:       mem.seq_ready = 1'b1;
                1:       mem.seq_ready = cyc[0];
                default: mem.seq_ready = 1'($urandom);
            endcase
            if (mode == 2) begin
                seq_start = 1'($urandom);
                seq_list  = 16'($urandom);
                seq_load  = 1'($urandom);
            end
            mem.seq_wdata = (exp_q.size() > 0) ? exp_q[0].data : $urandom;
            #2;
            if (seq_done) begin
                seen = 1'b1;
                break;
            end
            if (cyc >= 200) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("walk_done_seen", 32'(seen), 32'd1);
        if (seen) begin
            checkOutput("done_no_valid", 32'(mem.seq_valid), 32'd0);
            checkOutput("done_count", 32'(mem.seq_count), n);
            checkOutput("done_idx", 32'(mem.seq_idx), n);
        end
        if (mode == 0) checkOutput("done_latency", cyc, n + 1);
        @(posedge clk);
        #1;
        seq_start = 1'b0;
        mem.seq_ready = 1'b0;
        checkOutput("queue_drained", exp_q.size(), 0);
        checkOutput("idle_after_done", 32'(seq_done), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        clearControls();
        addr_Rn = 0; addr_Rm = 0; addr_Rd = 0;
        w_Rd = 0; w_SP = 0; w_LR = 0; w_PC = 0;
        w_APSR = 0; w_IPSR = 0; w_PMask = 0; w_spsel = 0;
        seq_start = 0; seq_load = 0; seq_list = 0;
        mem.seq_ready = 0; mem.seq_wdata = 0;
        for (int i = 0; i < 16; i++) m_r[i] = 32'h0;
        m_r[14] = 32'hFFFF_FFFF;
        m_msp = RST_SP; m_psp = 0; m_apsr = 0; m_ipsr = 0; m_pmask = 0; m_spsel = 0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        checkOutput("rst_LR", r_LR, 32'hFFFF_FFFF);
        checkOutput("rst_SP", r_SP, RST_SP);
        checkOutput("rst_PC", r_PC, 32'h0);
        checkOutput("rst_APSR", 32'(r_APSR), 32'h0);
        checkOutput("rst_PMask", 32'(r_PMask), 32'h0);
        checkOutput("rst_IPSR", 32'(r_IPSR), 32'h0);
        checkOutput("rst_valid", 32'(mem.seq_valid), 32'h0);
        checkOutput("rst_busy", 32'(seq_busy), 32'h0);
        checkOutput("rst_done", 32'(seq_done), 32'h0);
        checkOutput("rst_idx", 32'(mem.seq_idx), 32'h0);
        checkOutput("rst_count", 32'(mem.seq_count), 32'h0);
        @(posedge clk);
        #1;

        ld_spsel = 1; w_spsel = 1;
        applyStimulus();
        ld_rd = 1; addr_Rd = 4'd13; w_Rd = 32'h2000_1000;
        applyStimulus();
        checkOutput("psp_written", r_SP, 32'h2000_1000);
        checkStatus();
        ld_ipsr = 1; w_IPSR = 6'd3;
        applyStimulus();
        checkOutput("handler_uses_msp", r_SP, RST_SP);
        ld_ipsr = 1; w_IPSR = 6'd0;
        applyStimulus();
        checkStatus();

        addr_Rn = 4'd2; ld_rd = 1; addr_Rd = 4'd2; w_Rd = 32'h55;
        applyStimulus();
        checkOutput("r2_after_write", Rn, 32'h55);

        ld_pc = 1; w_PC = 32'h1234; ld_rd = 1; addr_Rd = 4'd15; w_Rd = 32'hDEAD;
        applyStimulus();
        checkOutput("pc_beats_rd", r_PC, 32'h1234);

        runWalk(1'b0, 16'h40F1, 0);
        runWalk(1'b1, 16'h8003, 1);
        checkOutput("pop_pc", r_PC, 32'hC);
        runWalk(1'b0, 16'h0000, 0);

        for (int it = 0; it < 40; it++) begin
            ld_rd = 1'($urandom); addr_Rd = 4'($urandom); w_Rd = $urandom;
            ld_sp = ($urandom_range(3, 0) == 0); w_SP = $urandom;
            ld_lr = ($urandom_range(3, 0) == 0); w_LR = $urandom;
            ld_pc = ($urandom_range(3, 0) == 0); w_PC = $urandom;
            ld_apsr = 1'($urandom); w_APSR = 4'($urandom);
            ld_ipsr = ($urandom_range(5, 0) == 0);
            w_IPSR = ($urandom_range(1, 0) == 0) ? 6'd0 : 6'($urandom);
            ld_primask = 1'($urandom); w_PMask = 1'($urandom);
            ld_spsel = ($urandom_range(3, 0) == 0); w_spsel = 1'($urandom);
            addr_Rn = 4'($urandom); addr_Rm = 4'($urandom);
            applyStimulus();
            checkStatus();
        end

        for (int w = 0; w < 8; w++) begin
            runWalk(1'($urandom), 16'($urandom), (w < 2) ? 0 : 2);
            ld_spsel = 1'($urandom); w_spsel = 1'($urandom);
            ld_ipsr = 1'($urandom);
            w_IPSR = ($urandom_range(1, 0) == 0) ? 6'd0 : 6'($urandom);
            applyStimulus();
        end
        checkAllRegs();
        checkStatus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
